// File: rtl/hex_display_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hex_display_arbiter                                        |
// | Description : Round-robin owner arbitration of the 7-segment display     |
// |               value between the CPU GPIO port and a debug snapshot port, |
// |               with a minimum dwell time per grant and registered         |
// |               leading-zero blank flags for the hexdriver array.          |
// | Ports       : clk, rst (async, active-low)                               |
// |               cpu_valid/cpu_data/cpu_ready   CPU write handshake         |
// |               dbg_valid/dbg_data/dbg_ready   debug write handshake       |
// |               blank_lz                       leading-zero blank enable   |
// |               disp_val/disp_blank            value and per-digit blanks  |
// |               disp_src                       0 = CPU, 1 = debug          |
// |               hold_active                    high while a grant dwells   |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module hex_display_arbiter #(
   parameter int NUM_DIGITS  = 8,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int HOLD_W      = $clog2(HOLD_CYCLES + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cpu_valid,
   input  logic [4*NUM_DIGITS-1:0]   cpu_data,
   output logic                      cpu_ready,
   input  logic                      dbg_valid,
   input  logic [4*NUM_DIGITS-1:0]   dbg_data,
   output logic                      dbg_ready,
   input  logic                      blank_lz,
   output logic [4*NUM_DIGITS-1:0]   disp_val,
   output logic [NUM_DIGITS-1:0]     disp_blank,
   output logic                      disp_src,
   output logic                      hold_active
);

   localparam int DW = 4 * NUM_DIGITS;

   localparam logic              c_src_cpu = 1'b0;
   localparam logic              c_src_dbg = 1'b1;
   localparam logic [HOLD_W-1:0] c_reload  = HOLD_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_HOLD_CPU = 2'd1,
      S_HOLD_DBG = 2'd2
   } state_t;

   state_t              state_q,      state_d;
   logic [HOLD_W-1:0]   cnt_q,        cnt_d;
   logic [DW-1:0]       disp_val_q,   disp_val_d;
   logic [NUM_DIGITS-1:0] disp_blank_q, disp_blank_d;
   logic                disp_src_q,   disp_src_d;
   logic                last_src_q,   last_src_d;
   logic                upper_zero;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      disp_val_d = disp_val_q;
      disp_src_d = disp_src_q;
      last_src_d = last_src_q;
      cpu_ready  = 1'b0;
      dbg_ready  = 1'b0;

      case (state_q)
         S_IDLE: begin
            // On a tie the source that did not own the display last wins.
            cpu_ready = cpu_valid & (~dbg_valid | (last_src_q == c_src_dbg));
            dbg_ready = dbg_valid & (~cpu_valid | (last_src_q == c_src_cpu));
            if (cpu_ready) begin
               disp_val_d = cpu_data;
               disp_src_d = c_src_cpu;
               last_src_d = c_src_cpu;
               cnt_d      = c_reload;
               state_d    = S_HOLD_CPU;
            end else if (dbg_ready) begin
               disp_val_d = dbg_data;
               disp_src_d = c_src_dbg;
               last_src_d = c_src_dbg;
               cnt_d      = c_reload;
               state_d    = S_HOLD_DBG;
            end
         end

         S_HOLD_CPU: begin
            cpu_ready = 1'b1;
            if (cpu_valid) begin
               disp_val_d = cpu_data;
            end
            // Owner refreshes only extend the dwell while the other side is
            // quiet; a pending contender lets the count run out.
            if (cpu_valid && !dbg_valid) begin
               cnt_d = c_reload;
            end else if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_HOLD_DBG: begin
            dbg_ready = 1'b1;
            if (dbg_valid) begin
               disp_val_d = dbg_data;
            end
            if (dbg_valid && !cpu_valid) begin
               cnt_d = c_reload;
            end else if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Blank flags follow the value being loaded so they land in the same
   // cycle as disp_val. Scan from the top digit down; digit 0 is never blanked.
   always_comb begin
      disp_blank_d = '0;
      upper_zero   = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         upper_zero      = upper_zero & (disp_val_d[4*i +: 4] == 4'h0);
         disp_blank_d[i] = blank_lz & upper_zero;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         disp_val_q   <= '0;
         disp_blank_q <= '0;
         disp_src_q   <= c_src_cpu;
         last_src_q   <= c_src_dbg;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         disp_val_q   <= disp_val_d;
         disp_blank_q <= disp_blank_d;
         disp_src_q   <= disp_src_d;
         last_src_q   <= last_src_d;
      end
   end

   assign disp_val    = disp_val_q;
   assign disp_blank  = disp_blank_q;
   assign disp_src    = disp_src_q;
   assign hold_active = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_hex_display_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hex_display_arbiter                                     |
// | Description : Directed vector table plus hand-written multi-cycle        |
// |               sequences for hex_display_arbiter (HOLD_CYCLES = 4).       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_hex_display_arbiter;

   logic        clk;
   logic        rst;
   logic        cpu_valid;
   logic [31:0] cpu_data;
   logic        cpu_ready;
   logic        dbg_valid;
   logic [31:0] dbg_data;
   logic        dbg_ready;
   logic        blank_lz;
   logic [31:0] disp_val;
   logic [7:0]  disp_blank;
   logic        disp_src;
   logic        hold_active;

   int n_vec = 0;
   int n_err = 0;

   hex_display_arbiter #(
      .NUM_DIGITS  (8),
      .HOLD_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_valid   (cpu_valid),
      .cpu_data    (cpu_data),
      .cpu_ready   (cpu_ready),
      .dbg_valid   (dbg_valid),
      .dbg_data    (dbg_data),
      .dbg_ready   (dbg_ready),
      .blank_lz    (blank_lz),
      .disp_val    (disp_val),
      .disp_blank  (disp_blank),
      .disp_src    (disp_src),
      .hold_active (hold_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        cv;
      logic [31:0] cd;
      logic        dv;
      logic [31:0] dd;
      logic        blz;
      logic        cr;
      logic        dr;
      logic [31:0] val;
      logic [7:0]  blank;
      logic        src;
      logic        hold;
   } vec_t;

   function automatic vec_t mk(input logic cv, input logic [31:0] cd,
                               input logic dv, input logic [31:0] dd,
                               input logic blz, input logic cr, input logic dr,
                               input logic [31:0] val, input logic [7:0] blank,
                               input logic src, input logic hold);
      vec_t v;
      v.cv = cv; v.cd = cd; v.dv = dv; v.dd = dd; v.blz = blz;
      v.cr = cr; v.dr = dr; v.val = val; v.blank = blank; v.src = src; v.hold = hold;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Inputs change on the falling edge; ready is checked before the rising
   // edge, registered outputs just after it.
   task automatic run_vec(input vec_t v, input int idx);
      @(negedge clk);
      cpu_valid = v.cv; cpu_data = v.cd;
      dbg_valid = v.dv; dbg_data = v.dd;
      blank_lz  = v.blz;
      #1;
      chk($sformatf("v%0d cpu_ready", idx), {31'd0, cpu_ready}, {31'd0, v.cr});
      chk($sformatf("v%0d dbg_ready", idx), {31'd0, dbg_ready}, {31'd0, v.dr});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d disp_val", idx), disp_val, v.val);
      chk($sformatf("v%0d disp_blank", idx), {24'd0, disp_blank}, {24'd0, v.blank});
      chk($sformatf("v%0d disp_src", idx), {31'd0, disp_src}, {31'd0, v.src});
      chk($sformatf("v%0d hold_active", idx), {31'd0, hold_active}, {31'd0, v.hold});
   endtask

   vec_t        vecs[$];
   logic [31:0] exp_val;
   int          got;

   initial begin
      //             cv cd            dv dd            blz cr dr val           blank         src hold
      vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0,  0, 0, 32'h00000000, 8'h00,        0, 0)); // 0 reset state
      vecs.push_back(mk(1, 32'h11111111, 1, 32'h22222222, 0,  1, 0, 32'h11111111, 8'h00,        0, 1)); // 1 tie: CPU first
      vecs.push_back(mk(1, 32'h33333333, 1, 32'h22222222, 0,  1, 0, 32'h33333333, 8'h00,        0, 1)); // 2 cnt 3->2
      vecs.push_back(mk(0, 32'h0,        1, 32'h22222222, 0,  1, 0, 32'h33333333, 8'h00,        0, 1)); // 3 cnt 2->1
      vecs.push_back(mk(0, 32'h0,        1, 32'h22222222, 0,  1, 0, 32'h33333333, 8'h00,        0, 1)); // 4 cnt 1->0
      vecs.push_back(mk(0, 32'h0,        1, 32'h22222222, 0,  1, 0, 32'h33333333, 8'h00,        0, 0)); // 5 -> IDLE
      vecs.push_back(mk(1, 32'h44444444, 1, 32'hDEADBEEF, 0,  0, 1, 32'hDEADBEEF, 8'h00,        1, 1)); // 6 debug wins
      vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0,  0, 1, 32'hDEADBEEF, 8'h00,        1, 1)); // 7 cnt 3->2
      vecs.push_back(mk(0, 32'h0,        1, 32'h00000A05, 1,  0, 1, 32'h00000A05, 8'b1111_1000, 1, 1)); // 8 blank, reload
      vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0,  0, 1, 32'h00000A05, 8'h00,        1, 1)); // 9 blank_lz off
      vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1,  0, 1, 32'h00000A05, 8'b1111_1000, 1, 1)); // 10 blank_lz on
      vecs.push_back(mk(0, 32'h0,        1, 32'h00000000, 1,  0, 1, 32'h00000000, 8'b1111_1110, 1, 1)); // 11 all zero
      vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1,  0, 1, 32'h00000000, 8'b1111_1110, 1, 1)); // 12 cnt 2
      vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1,  0, 1, 32'h00000000, 8'b1111_1110, 1, 1)); // 13 cnt 1
      vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1,  0, 1, 32'h00000000, 8'b1111_1110, 1, 1)); // 14 cnt 0
      vecs.push_back(mk(0, 32'h0,        0, 32'h0,        1,  0, 1, 32'h00000000, 8'b1111_1110, 1, 0)); // 15 -> IDLE
      vecs.push_back(mk(1, 32'h00001234, 0, 32'h0,        0,  1, 0, 32'h00001234, 8'h00,        0, 1)); // 16 CPU grant
      vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0,  1, 0, 32'h00001234, 8'h00,        0, 1)); // 17 cnt 2
      vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0,  1, 0, 32'h00001234, 8'h00,        0, 1)); // 18 cnt 1
      vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0,  1, 0, 32'h00001234, 8'h00,        0, 1)); // 19 cnt 0
      vecs.push_back(mk(1, 32'h00005678, 0, 32'h0,        0,  1, 0, 32'h00005678, 8'h00,        0, 1)); // 20 cnt0 refresh: stay
      vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0,  1, 0, 32'h00005678, 8'h00,        0, 1)); // 21 cnt 2
      vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0,  1, 0, 32'h00005678, 8'h00,        0, 1)); // 22 cnt 1
      vecs.push_back(mk(0, 32'h0,        0, 32'h0,        0,  1, 0, 32'h00005678, 8'h00,        0, 1)); // 23 cnt 0
      vecs.push_back(mk(1, 32'h0000ABCD, 1, 32'h00009999, 0,  1, 0, 32'h0000ABCD, 8'h00,        0, 0)); // 24 cnt0 + pending
      vecs.push_back(mk(1, 32'h00001111, 1, 32'h00009999, 0,  0, 1, 32'h00009999, 8'h00,        1, 1)); // 25 debug wins

      rst = 1'b0;
      cpu_valid = 1'b0; cpu_data = '0;
      dbg_valid = 1'b0; dbg_data = '0;
      blank_lz  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst disp_val", disp_val, 32'h0);
      chk("rst hold_active", {31'd0, hold_active}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Reset in the middle of a debug hold acts without a clock edge.
      @(negedge clk);
      cpu_valid = 1'b0;
      dbg_valid = 1'b1; dbg_data = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      chk("pre_rst disp_val", disp_val, 32'hDEADBEEF);
      chk("pre_rst hold_active", {31'd0, hold_active}, 32'd1);
      dbg_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst disp_val", disp_val, 32'h0);
      chk("async_rst disp_src", {31'd0, disp_src}, 32'd0);
      chk("async_rst hold_active", {31'd0, hold_active}, 32'd0);
      chk("async_rst disp_blank", {24'd0, disp_blank}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      cpu_valid = 1'b1; cpu_data = 32'h00001234;
      #1;
      chk("post_rst cpu_ready", {31'd0, cpu_ready}, 32'd1);
      @(posedge clk);
      #1;
      chk("post_rst disp_val", disp_val, 32'h00001234);
      chk("post_rst disp_src", {31'd0, disp_src}, 32'd0);

      // Owner refresh every other cycle keeps the CPU hold alive.
      exp_val = 32'h00001234;
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         cpu_valid = (k % 2 == 0);
         cpu_data  = 32'h01000000 + k;
         dbg_valid = 1'b0;
         @(posedge clk);
         #1;
         if (k % 2 == 0) exp_val = 32'h01000000 + k;
         chk($sformatf("refresh%0d hold_active", k), {31'd0, hold_active}, 32'd1);
         chk($sformatf("refresh%0d disp_val", k), disp_val, exp_val);
      end

      // CPU writes every cycle; the debug request must still get through.
      got = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         cpu_valid = 1'b1; cpu_data = 32'h02000000 + k;
         dbg_valid = 1'b1; dbg_data = 32'hCAFE0001;
         @(posedge clk);
         #1;
         if (disp_src == 1'b1) begin
            got = k;
            break;
         end
      end
      n_vec++;
      if (got == 0 || got > 5) begin
         n_err++;
         $display("FAIL starve_latency: got %0d cycles expected 1..5", got);
      end
      chk("starve disp_val", disp_val, 32'hCAFE0001);
      chk("starve disp_src", {31'd0, disp_src}, 32'd1);

      @(negedge clk);
      cpu_valid = 1'b0;
      dbg_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
